// File: rtl/sensor_gen_pkg.sv
// sensor_gen_pkg: shared types and constants for the synthetic sensor source.
// Holds the timing FSM states, pattern modes and LFSR constants.
package sensor_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HBLANK,
    VBLANK
  } state_t;

  typedef enum logic [1:0] {
    MODE_RAMP,
    MODE_CNT1000,
    MODE_CHECKER,
    MODE_LFSR
  } mode_t;

  localparam logic [11:0] LFSR_SEED = 12'hACE;
  // x^12+x^6+x^4+x+1 -> state bits 11,5,3,0
  localparam logic [11:0] LFSR_TAPS = 12'b1000_0010_1001;
  localparam logic [9:0]  C1K_LAST  = 10'd999;

  function automatic logic [11:0] lfsr_next(
    input logic [11:0] q
  );
    return {q[10:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sensor_gen_timing.sv
// sensor_gen_timing: raster FSM with x/y and blanking counters.
// Latches the pattern mode at every frame start.
module sensor_gen_timing
  import sensor_gen_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 16,
  parameter int V_ACTIVE = 960,
  parameter int V_BLANK  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic [1:0]  i_mode,
  output state_t      o_state,
  output logic [10:0] o_x,
  output logic [9:0]  o_y,
  output mode_t       o_mode,
  output logic        o_sof,
  output logic        o_vbe
);

  localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST =
    16'(V_BLANK * (H_ACTIVE + H_BLANK) - 1);

  state_t      r_state;
  mode_t       r_mode;
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic [15:0] r_bcnt;

  // raster walk: active pixels, line blank, frame blank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mode  <= MODE_RAMP;
      r_x     <= '0;
      r_y     <= '0;
      r_bcnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_enable) begin
            r_state <= ACTIVE;
            r_mode  <= mode_t'(i_mode);
            r_x     <= '0;
            r_y     <= '0;
          end
        end
        ACTIVE: begin
          if (r_x == X_LAST) begin
            r_state <= HBLANK;
            r_bcnt  <= '0;
          end else begin
            r_x <= r_x + 11'd1;
          end
        end
        HBLANK: begin
          if (r_bcnt == HB_LAST) begin
            r_bcnt <= '0;
            if (r_y == Y_LAST) begin
              r_state <= VBLANK;
            end else begin
              r_state <= ACTIVE;
              r_x     <= '0;
              r_y     <= r_y + 10'd1;
            end
          end else begin
            r_bcnt <= r_bcnt + 16'd1;
          end
        end
        VBLANK: begin
          if (r_bcnt == VB_LAST) begin
            r_bcnt <= '0;
            r_x    <= '0;
            r_y    <= '0;
            if (i_enable) begin
              r_state <= ACTIVE;
              r_mode  <= mode_t'(i_mode);
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_bcnt <= r_bcnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_mode  = r_mode;
  assign o_sof   = (r_state == ACTIVE) &&
                   (r_x == '0) && (r_y == '0);
  assign o_vbe   = (r_state == VBLANK) &&
                   (r_bcnt == '0);

endmodule

// File: rtl/sensor_stream_gen.sv
// sensor_stream_gen: synthetic raw-pixel source with blanking.
// Mode 3 LFSR stream only when SENSOR_GEN_LFSR_EN is defined.
module sensor_stream_gen
  import sensor_gen_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 16,
  parameter int V_ACTIVE = 960,
  parameter int V_BLANK  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iEnable,
  input  logic [1:0]        iMode,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic              oFVAL,
  output logic [10:0]       oX,
  output logic [9:0]        oY,
  output logic [31:0]       oFrame_Cont
);

  state_t      w_state;
  mode_t       w_mode;
  logic [10:0] w_x;
  logic [9:0]  w_y;
  logic        w_sof;
  logic        w_vbe;
  logic        w_act;
  logic [9:0]  w_c1k;
  logic [DATA_W-1:0] w_pix;

  logic [DATA_W-1:0] r_data;
  logic        r_dval;
  logic        r_fval;
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic [31:0] r_fcnt;
  logic [9:0]  r_c1k;

  sensor_gen_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .V_BLANK  (V_BLANK)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (iEnable),
    .i_mode   (iMode),
    .o_state  (w_state),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_mode   (w_mode),
    .o_sof    (w_sof),
    .o_vbe    (w_vbe)
  );

  assign w_act = (w_state == ACTIVE);
  assign w_c1k = w_sof ? 10'd1 : r_c1k;

`ifdef SENSOR_GEN_LFSR_EN
  logic [11:0] r_lfsr;
  logic [11:0] w_lfsr;

  assign w_lfsr = w_sof ? LFSR_SEED : r_lfsr;

  // LFSR restarts each frame, steps once per valid pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_act) begin
      r_lfsr <= lfsr_next(w_lfsr);
    end
  end
`endif

  // pattern value for the pixel the timing FSM is on
  always_comb begin
    w_pix = DATA_W'(w_x);
    case (w_mode)
      MODE_CNT1000: w_pix = DATA_W'(w_c1k);
      MODE_CHECKER: w_pix = (w_x[3] ^ w_y[3]) ? '1 : '0;
`ifdef SENSOR_GEN_LFSR_EN
      MODE_LFSR:    w_pix = DATA_W'(w_lfsr);
`endif
      default:      w_pix = DATA_W'(w_x);
    endcase
  end

  // output registers, wrapping 1..999,0 counter, frame count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_dval <= 1'b0;
      r_fval <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_fcnt <= '0;
      r_c1k  <= '0;
    end else begin
      r_dval <= w_act;
      r_fval <= w_act || (w_state == HBLANK);
      if (w_act) begin
        r_data <= w_pix;
        r_x    <= w_x;
        r_y    <= w_y;
        r_c1k  <= (w_c1k == C1K_LAST) ? '0 : w_c1k + 10'd1;
      end else if (w_state == IDLE) begin
        r_data <= '0;
        r_x    <= '0;
        r_y    <= '0;
      end
      if (w_vbe) begin
        r_fcnt <= r_fcnt + 32'd1;
      end
    end
  end

  assign oDATA       = r_data;
  assign oDVAL       = r_dval;
  assign oFVAL       = r_fval;
  assign oX          = r_x;
  assign oY          = r_y;
  assign oFrame_Cont = r_fcnt;

endmodule

// File: doc/sensor_stream_gen.md
# sensor_stream_gen

Synthetic raw-pixel source that drives the image-processing pipeline's input in place of the camera capture path. Emits 12-bit raw pixels with per-pixel valid, frame-valid and X/Y coordinates, with line and frame blanking, so the downstream processing chain can be exercised on the board and in simulation with deterministic, repeatable frames. Sits between the board's mode switches and the processing block's pixel input. It is the producing end of the pixel-stream interface that block consumes.

## Interface
Parameters:
- DATA_W, 12, pixel width
- H_ACTIVE, 1280, active pixels per line
- H_BLANK, 16, blank cycles after each line
- V_ACTIVE, 960, active lines per frame
- V_BLANK, 4, blank lines after each frame (each blank line is H_ACTIVE+H_BLANK cycles)

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- iEnable  in  1  run request
- iMode  in  2  pattern select, sampled at frame start
- oDATA  out  DATA_W  pixel value
- oDVAL  out  1  pixel valid
- oFVAL  out  1  frame valid
- oX  out  11  column of current pixel
- oY  out  10  row of current pixel
- oFrame_Cont  out  32  completed-frame count

## Operation
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE: all outputs held at 0 except oFrame_Cont. iEnable=1 sampled -> ACTIVE, latches iMode, clears x, y, pixel index n.
- ACTIVE: one pixel per cycle, oDVAL=1, oFVAL=1, x increments. At x=H_ACTIVE-1 -> HBLANK.
- HBLANK: H_BLANK cycles, oDVAL=0, oFVAL=1, oDATA holds last value. Then y increments; y=V_ACTIVE-1 done -> VBLANK, else ACTIVE with x=0.
- VBLANK: V_BLANK*(H_ACTIVE+H_BLANK) cycles, oDVAL=0, oFVAL=0. Then iEnable=1 -> ACTIVE (new frame, re-latch iMode), else IDLE.
- oFrame_Cont increments once, on the cycle of entering VBLANK; wraps at 2^32.
- Patterns (n = pixel index within frame, 0-based):
  - 0: horizontal ramp, oDATA = x[11:0].
  - 1: counter, oDATA = (n+1) mod 1000; n resets each frame.
  - 2: checkerboard, oDATA = (x[3]^y[3]) ? 12'hFFF : 12'h000.
  - 3: see Configuration.
- Boundary rules:
  - iEnable dropped mid-frame: current frame completes, including VBLANK. Then IDLE.
  - iMode change mid-frame: ignored until next frame start.
  - rst_n asserted mid-frame: immediate return to IDLE. All outputs 0, oFrame_Cont 0, counters 0, LFSR reseeded.
  - The mod-1000 counter is a wrapping counter 0..999, not a divider.

## Timing
- All outputs registered. Reset value 0 for every output.
- Latency: iEnable sampled high at edge k in IDLE -> first oDVAL=1 (x=0, y=0) visible after edge k+1.
- Frame period: (V_ACTIVE+V_BLANK)*(H_ACTIVE+H_BLANK) cycles. Back-to-back frames with no IDLE gap while iEnable stays high.
- oX/oY/oDATA are mutually aligned with oDVAL on the same cycle.
- oFVAL rises with the first oDVAL of a frame. It falls the cycle after the last HBLANK cycle of line V_ACTIVE-1.

## Configuration
- SENSOR_GEN_LFSR_EN defined:
  - Mode 3 is a pseudo-random pixel stream from a 12-bit Fibonacci LFSR, polynomial x^12+x^6+x^4+x+1, seed 12'hACE.
  - Reseeded at each frame start. Advances only on oDVAL cycles.
- Not defined: mode 3 aliases mode 0, and no LFSR logic is synthesized.

## Structure
- Package sensor_gen_pkg: state enum (IDLE, ACTIVE, HBLANK, VBLANK), mode enum (MODE_RAMP, MODE_CNT1000, MODE_CHECKER, MODE_LFSR), LFSR seed/taps constants.
- One sub-module: sensor_gen_timing. It holds the FSM and the x/y/blank counters and outputs the current position and state. The top level holds pattern generation and output registers.

## Test plan
Bench parameters: H_ACTIVE=8, H_BLANK=2, V_ACTIVE=4, V_BLANK=1.
- Reset with iEnable=1, then release -> first oDVAL one edge after iEnable sampled; 32 oDVAL pulses; per line, 8 valid and 2 blank cycles; oFVAL low for exactly 10 cycles; oFrame_Cont=1 at VBLANK entry.
- Mode 1 for 3 frames -> oDATA sequence 1..32 each frame (n resets per frame); at H_ACTIVE=1280, verify wrap 999->0 at n=999.
- Mode 0 -> oDATA equals oX on every valid cycle. Switch iMode to 2 mid-frame -> no change until next frame, then checkerboard values.
- Drop iEnable at line 1 -> frame completes, VBLANK runs, enter IDLE with outputs 0; re-raise -> new frame starts at x=0, y=0.
- Assert rst_n=0 mid-line -> all outputs 0 asynchronously, without waiting for a clock edge; oFrame_Cont=0.
- With SENSOR_GEN_LFSR_EN, mode 3 -> first pixel 12'hACE, identical sequence each frame. Without it, mode 3 -> matches mode 0.
